// File: rtl/wb_master_pkg.sv
// wb_master_pkg: engine FSM states and response status codes for wb_master_engine.
package wb_master_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUS     = 2'd1,
        S_BACKOFF = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_ERR     = 2'd1,
        ST_RTY_EXH = 2'd2,
        ST_TIMEOUT = 2'd3
    } status_t;

    localparam logic [1:0] STATUS_OK       = 2'd0;
    localparam logic [1:0] STATUS_ERR      = 2'd1;
    localparam logic [1:0] STATUS_RTY_EXH  = 2'd2;
    localparam logic [1:0] STATUS_TIMEOUT  = 2'd3;

endpackage

// File: rtl/wb_master_engine.sv
// wb_master_engine: single-command Wishbone master with retry handling and a response channel.
// Optional bus-phase watchdog is compiled in with WB_MASTER_TIMEOUT_EN.
module wb_master_engine
    import wb_master_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TAG_W     = 16,
    parameter int unsigned MAX_RETRY = 4,
    parameter int unsigned TIMEOUT   = 256,
    localparam int unsigned SEL_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic              cmd_lock,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic [TAG_W-1:0]  cmd_tga,
    input  logic [TAG_W-1:0]  cmd_tgd,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tgd,
    output logic [1:0]        rsp_status,
    output logic [ADDR_W-1:0] ADR_O,
    output logic [DATA_W-1:0] DAT_O,
    output logic [SEL_W-1:0]  SEL_O,
    output logic [TAG_W-1:0]  TGA_O,
    output logic [TAG_W-1:0]  TGD_O,
    output logic              WE_O,
    output logic              CYC_O,
    output logic              STB_O,
    output logic              LOCK_O,
    input  logic [DATA_W-1:0] DAT_I,
    input  logic [TAG_W-1:0]  TGD_I,
    input  logic              ACK_I,
    input  logic              ERR_I,
    input  logic              RTY_I
);

    localparam int unsigned RW = $clog2(MAX_RETRY + 2);

    state_t            state_q, state_d;
    logic              we_q, we_d, lock_q, lock_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [TAG_W-1:0]  tga_q, tga_d, tgd_q, tgd_d;
    logic [RW-1:0]     retry_q, retry_d, retry_nx;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]  rsp_tgd_q, rsp_tgd_d;
    logic [1:0]        rsp_status_q, rsp_status_d;
    logic              bus, backoff;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    assign bus        = state_q == S_BUS;
    assign backoff    = state_q == S_BACKOFF;
    assign cmd_ready  = state_q == S_IDLE;
    assign rsp_valid  = state_q == S_RESP;
    assign rsp_data   = rsp_data_q;
    assign rsp_tgd    = rsp_tgd_q;
    assign rsp_status = rsp_status_q;
    assign ADR_O      = bus ? adr_q : '0;
    assign DAT_O      = bus ? dat_q : '0;
    assign SEL_O      = bus ? sel_q : '0;
    assign TGA_O      = bus ? tga_q : '0;
    assign TGD_O      = bus ? tgd_q : '0;
    assign WE_O       = bus & we_q;
    assign STB_O      = bus;
    // A locked command keeps the cycle (and the lock) through the retry gap.
    assign CYC_O      = bus | (backoff & lock_q);
    assign LOCK_O     = lock_q & (bus | backoff);
    assign retry_nx   = retry_q + RW'(1);

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        lock_d       = lock_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        tga_d        = tga_q;
        tgd_d        = tgd_q;
        retry_d      = retry_q;
        rsp_data_d   = rsp_data_q;
        rsp_tgd_d    = rsp_tgd_q;
        rsp_status_d = rsp_status_q;
`ifdef WB_MASTER_TIMEOUT_EN
        tmo_d        = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_BUS;
                    we_d    = cmd_we;
                    lock_d  = cmd_lock;
                    adr_d   = cmd_addr;
                    dat_d   = cmd_data;
                    sel_d   = cmd_sel;
                    tga_d   = cmd_tga;
                    tgd_d   = cmd_tgd;
                    retry_d = '0;
`ifdef WB_MASTER_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            S_BUS: begin
                if (ERR_I) begin
                    state_d      = S_RESP;
                    rsp_status_d = STATUS_ERR;
                    rsp_data_d   = '0;
                    rsp_tgd_d    = '0;
                end else if (RTY_I) begin
                    retry_d = retry_nx;
                    if (32'(retry_nx) >= MAX_RETRY) begin
                        state_d      = S_RESP;
                        rsp_status_d = STATUS_RTY_EXH;
                        rsp_data_d   = '0;
                        rsp_tgd_d    = '0;
                    end else begin
                        state_d = S_BACKOFF;
                    end
                end else if (ACK_I) begin
                    state_d      = S_RESP;
                    rsp_status_d = STATUS_OK;
                    rsp_data_d   = we_q ? '0 : DAT_I;
                    rsp_tgd_d    = we_q ? '0 : TGD_I;
                end
`ifdef WB_MASTER_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d      = S_RESP;
                    rsp_status_d = STATUS_TIMEOUT;
                    rsp_data_d   = '0;
                    rsp_tgd_d    = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            S_BACKOFF: begin
                state_d = S_BUS;
`ifdef WB_MASTER_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    retry_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            lock_q       <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            tga_q        <= '0;
            tgd_q        <= '0;
            retry_q      <= '0;
            rsp_data_q   <= '0;
            rsp_tgd_q    <= '0;
            rsp_status_q <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            lock_q       <= lock_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            tga_q        <= tga_d;
            tgd_q        <= tgd_d;
            retry_q      <= retry_d;
            rsp_data_q   <= rsp_data_d;
            rsp_tgd_q    <= rsp_tgd_d;
            rsp_status_q <= rsp_status_d;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_wb_master_engine.sv
// tb_wb_master_engine: scoreboard bench for wb_master_engine (TIMEOUT=8, other parameters default).
// Timeout expectations follow WB_MASTER_TIMEOUT_EN.
module tb_wb_master_engine;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] data;
        logic [15:0] tgd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0, cmd_lock = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_data = '0;
    logic [3:0]  cmd_sel = '0;
    logic [15:0] cmd_tga = '0, cmd_tgd = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [15:0] rsp_tgd;
    logic [1:0]  rsp_status;
    logic [31:0] ADR_O, DAT_O;
    logic [3:0]  SEL_O;
    logic [15:0] TGA_O, TGD_O;
    logic        WE_O, CYC_O, STB_O, LOCK_O;
    logic [31:0] DAT_I = '0;
    logic [15:0] TGD_I = '0;
    logic        ACK_I = 1'b0, ERR_I = 1'b0, RTY_I = 1'b0;

    always #5 clk = ~clk;

    wb_master_engine #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_lock(cmd_lock),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_sel(cmd_sel), .cmd_tga(cmd_tga), .cmd_tgd(cmd_tgd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tgd(rsp_tgd),
        .rsp_status(rsp_status),
        .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .TGA_O(TGA_O), .TGD_O(TGD_O),
        .WE_O(WE_O), .CYC_O(CYC_O), .STB_O(STB_O), .LOCK_O(LOCK_O),
        .DAT_I(DAT_I), .TGD_I(TGD_I), .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I)
    );

    // Called at a negedge; returns at the negedge where the command is in its first BUS cycle.
    task automatic issue(input logic we, input logic lk, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [15:0] ta, input logic [15:0] td);
        bit ok = 0;
        cmd_we = we; cmd_lock = lk; cmd_addr = a; cmd_data = d; cmd_sel = s; cmd_tga = ta; cmd_tgd = td;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        if (!ok) begin
            checks++;
            $display("FAIL issue_accept: cmd_ready never seen for addr %h", a);
        end
    endtask

    // Waits (bounded) for a response and handshakes it.
    task automatic get_rsp(output bit got, output logic [1:0] st, output logic [31:0] d, output logic [15:0] t);
        got = 0; st = 'x; d = 'x; t = 'x;
        for (int i = 0; i < 50; i++) begin
            if (rsp_valid) begin
                got = 1; st = rsp_status; d = rsp_data; t = rsp_tgd;
                rsp_ready = 1'b1;
                @(negedge clk);
                rsp_ready = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); else passed++;
        checks++; if ({CYC_O, STB_O, WE_O, LOCK_O} !== 4'b0) $display("FAIL reset_bus_ctl got %b want 0000", {CYC_O, STB_O, WE_O, LOCK_O}); else passed++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else passed++;
        checks++; if ({ADR_O, DAT_O, SEL_O, TGA_O, TGD_O} !== '0) $display("FAIL reset_bus_fields got %h want 0", {ADR_O, DAT_O, SEL_O, TGA_O, TGD_O}); else passed++;
        checks++; if ({rsp_data, rsp_tgd, rsp_status} !== '0) $display("FAIL reset_rsp_fields got %h want 0", {rsp_data, rsp_tgd, rsp_status}); else passed++;
    endtask

    task automatic test_write();
        bit got; logic [1:0] st; logic [31:0] d; logic [15:0] t; exp_t e;
        sb.push_back('{2'd0, 32'h0, 16'h0});
        issue(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'hF, 16'h0011, 16'h0022);
        checks++; if ({CYC_O, STB_O, WE_O, SEL_O, ADR_O, DAT_O, TGA_O, TGD_O} !== {3'b111, 4'hF, 32'h100, 32'hDEADBEEF, 16'h0011, 16'h0022})
            $display("FAIL write_bus1 got %b%b%b %h %h %h %h %h", CYC_O, STB_O, WE_O, SEL_O, ADR_O, DAT_O, TGA_O, TGD_O); else passed++;
        checks++; if (cmd_ready !== 1'b0) $display("FAIL write_busy_ready got %b want 0", cmd_ready); else passed++;
        @(negedge clk);
        ACK_I = 1'b1;
        checks++; if ({CYC_O, STB_O, WE_O, SEL_O, ADR_O, DAT_O} !== {3'b111, 4'hF, 32'h100, 32'hDEADBEEF})
            $display("FAIL write_bus2_stable got %b%b%b %h %h %h", CYC_O, STB_O, WE_O, SEL_O, ADR_O, DAT_O); else passed++;
        @(negedge clk);
        ACK_I = 1'b0;
        checks++; if ({rsp_valid, rsp_status, CYC_O, STB_O, WE_O} !== 6'b100000)
            $display("FAIL write_rsp_next got valid=%b st=%0d cyc=%b stb=%b we=%b want 1 0 0 0 0", rsp_valid, rsp_status, CYC_O, STB_O, WE_O); else passed++;
        get_rsp(got, st, d, t); e = sb.pop_front();
        checks++; if (!got || st !== e.st || d !== e.data || t !== e.tgd)
            $display("FAIL write_sb got %b/%0d/%h/%h want 1/%0d/%h/%h", got, st, d, t, e.st, e.data, e.tgd); else passed++;
    endtask

    task automatic test_read_hold();
        bit got; logic [1:0] st; logic [31:0] d; logic [15:0] t; exp_t e;
        sb.push_back('{2'd0, 32'h12345678, 16'hABCD});
        issue(1'b0, 1'b0, 32'h200, 32'h0, 4'hF, 16'h0001, 16'h0);
        checks++; if ({STB_O, WE_O, ADR_O} !== {2'b10, 32'h200}) $display("FAIL read_bus got stb=%b we=%b adr=%h", STB_O, WE_O, ADR_O); else passed++;
        ACK_I = 1'b1; DAT_I = 32'h12345678; TGD_I = 16'hABCD;
        @(negedge clk);
        ACK_I = 1'b0; DAT_I = 32'hFFFF0000; TGD_I = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({rsp_valid, rsp_data, cmd_ready} !== {1'b1, 32'h12345678, 1'b0})
                $display("FAIL read_hold%0d got valid=%b data=%h ready=%b want 1 12345678 0", i, rsp_valid, rsp_data, cmd_ready); else passed++;
            @(negedge clk);
        end
        get_rsp(got, st, d, t); e = sb.pop_front();
        checks++; if (!got || st !== e.st || d !== e.data || t !== e.tgd)
            $display("FAIL read_sb got %b/%0d/%h/%h want 1/%0d/%h/%h", got, st, d, t, e.st, e.data, e.tgd); else passed++;
        DAT_I = '0; TGD_I = '0;
    endtask

    task automatic test_retry(input logic lk);
        bit got; logic [1:0] st; logic [31:0] d; logic [15:0] t; exp_t e;
        int pulses = 0, gaps = 0, bad = 0;
        logic prev = 1'b0;
        sb.push_back('{2'd2, 32'h0, 16'h0});
        issue(1'b0, lk, 32'h300, 32'h0, 4'h3, 16'h0, 16'h0);
        RTY_I = 1'b1;
        for (int i = 0; i < 40 && !rsp_valid; i++) begin
            if (STB_O && !prev) pulses++;
            if (!STB_O) begin
                gaps++;
                if (CYC_O !== lk || LOCK_O !== lk) bad++;
            end else if (CYC_O !== 1'b1 || LOCK_O !== lk || ADR_O !== 32'h300) bad++;
            prev = STB_O;
            @(negedge clk);
        end
        RTY_I = 1'b0;
        checks++; if (pulses !== 4) $display("FAIL retry_pulses_lock%b got %0d want 4", lk, pulses); else passed++;
        checks++; if (gaps !== 3) $display("FAIL retry_gaps_lock%b got %0d want 3", lk, gaps); else passed++;
        checks++; if (bad !== 0) $display("FAIL retry_cyc_lock_lock%b got %0d bad cycles want 0", lk, bad); else passed++;
        checks++; if (LOCK_O !== 1'b0) $display("FAIL retry_lock_resp_lock%b got %b want 0", lk, LOCK_O); else passed++;
        get_rsp(got, st, d, t); e = sb.pop_front();
        checks++; if (!got || st !== e.st || d !== e.data || t !== e.tgd)
            $display("FAIL retry_sb_lock%b got %b/%0d/%h/%h want 1/%0d/%h/%h", lk, got, st, d, t, e.st, e.data, e.tgd); else passed++;
    endtask

    task automatic test_priority();
        bit got; logic [1:0] st; logic [31:0] d; logic [15:0] t; exp_t e;
        sb.push_back('{2'd1, 32'h0, 16'h0});
        issue(1'b0, 1'b0, 32'h400, 32'h0, 4'hF, 16'h0, 16'h0);
        ACK_I = 1'b1; ERR_I = 1'b1; DAT_I = 32'hCAFEF00D; TGD_I = 16'h7777;
        @(negedge clk);
        ACK_I = 1'b0; ERR_I = 1'b0;
        get_rsp(got, st, d, t); e = sb.pop_front();
        checks++; if (!got || st !== e.st || d !== e.data || t !== e.tgd)
            $display("FAIL err_ack_sb got %b/%0d/%h/%h want 1/%0d/%h/%h", got, st, d, t, e.st, e.data, e.tgd); else passed++;
        sb.push_back('{2'd0, 32'h5A5A5A5A, 16'h1234});
        issue(1'b0, 1'b0, 32'h404, 32'h0, 4'hF, 16'h0, 16'h0);
        ACK_I = 1'b1; RTY_I = 1'b1;
        @(negedge clk);
        ACK_I = 1'b0; RTY_I = 1'b0;
        checks++; if ({STB_O, CYC_O, rsp_valid} !== 3'b000) $display("FAIL rty_ack_backoff got stb=%b cyc=%b valid=%b want 000", STB_O, CYC_O, rsp_valid); else passed++;
        @(negedge clk);
        ACK_I = 1'b1; DAT_I = 32'h5A5A5A5A; TGD_I = 16'h1234;
        @(negedge clk);
        ACK_I = 1'b0; DAT_I = '0; TGD_I = '0;
        get_rsp(got, st, d, t); e = sb.pop_front();
        checks++; if (!got || st !== e.st || d !== e.data || t !== e.tgd)
            $display("FAIL rty_ack_sb got %b/%0d/%h/%h want 1/%0d/%h/%h", got, st, d, t, e.st, e.data, e.tgd); else passed++;
    endtask

    task automatic test_timeout();
        int cyc_cnt = 0, seen = 0;
        issue(1'b0, 1'b0, 32'h500, 32'h0, 4'hF, 16'h0, 16'h0);
`ifdef WB_MASTER_TIMEOUT_EN
        begin
            bit got; logic [1:0] st; logic [31:0] d; logic [15:0] t; exp_t e;
            sb.push_back('{2'd3, 32'h0, 16'h0});
            for (int i = 0; i < 50 && !rsp_valid; i++) begin
                if (CYC_O) cyc_cnt++;
                @(negedge clk);
            end
            checks++; if (cyc_cnt !== 8) $display("FAIL timeout_cycles got %0d want 8", cyc_cnt); else passed++;
            get_rsp(got, st, d, t); e = sb.pop_front();
            checks++; if (!got || st !== e.st || d !== e.data || t !== e.tgd)
                $display("FAIL timeout_sb got %b/%0d/%h/%h want 1/%0d/%h/%h", got, st, d, t, e.st, e.data, e.tgd); else passed++;
        end
`else
        for (int i = 0; i < 100; i++) begin
            if (CYC_O) cyc_cnt++;
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        checks++; if (cyc_cnt !== 100) $display("FAIL notimeout_cyc got %0d want 100", cyc_cnt); else passed++;
        checks++; if (seen !== 0) $display("FAIL notimeout_rsp got %0d want 0", seen); else passed++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid_bus();
        int seen = 0;
        issue(1'b1, 1'b1, 32'h600, 32'h11112222, 4'hF, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
        checks++; if (CYC_O !== 1'b1) $display("FAIL rstbus_pre_cyc got %b want 1", CYC_O); else passed++;
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({CYC_O, STB_O, LOCK_O, rsp_valid, ADR_O} !== '0)
            $display("FAIL rstbus_drop got cyc=%b stb=%b lock=%b valid=%b adr=%h want 0", CYC_O, STB_O, LOCK_O, rsp_valid, ADR_O); else passed++;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) $display("FAIL rstbus_ready got %b want 1", cmd_ready); else passed++;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) $display("FAIL rstbus_no_rsp got %0d want 0", seen); else passed++;
    endtask

    task automatic test_back_to_back();
        bit got; logic [1:0] st; logic [31:0] d; logic [15:0] t; exp_t e;
        sb.push_back('{2'd0, 32'h0, 16'h0});
        sb.push_back('{2'd0, 32'h87654321, 16'hBEEF});
        issue(1'b1, 1'b0, 32'h700, 32'hA5A5A5A5, 4'h1, 16'h0, 16'h0);
        ACK_I = 1'b1;
        @(negedge clk);
        ACK_I = 1'b0;
        checks++; if (cmd_ready !== 1'b0) $display("FAIL b2b_resp_ready got %b want 0", cmd_ready); else passed++;
        get_rsp(got, st, d, t); e = sb.pop_front();
        checks++; if (!got || st !== e.st || d !== e.data || t !== e.tgd)
            $display("FAIL b2b_first_sb got %b/%0d/%h/%h want 1/%0d/%h/%h", got, st, d, t, e.st, e.data, e.tgd); else passed++;
        issue(1'b0, 1'b0, 32'h704, 32'h0, 4'hF, 16'h0, 16'h0);
        checks++; if ({STB_O, WE_O, ADR_O} !== {2'b10, 32'h704}) $display("FAIL b2b_second_bus got stb=%b we=%b adr=%h", STB_O, WE_O, ADR_O); else passed++;
        ACK_I = 1'b1; DAT_I = 32'h87654321; TGD_I = 16'hBEEF;
        @(negedge clk);
        ACK_I = 1'b0; DAT_I = '0; TGD_I = '0;
        get_rsp(got, st, d, t); e = sb.pop_front();
        checks++; if (!got || st !== e.st || d !== e.data || t !== e.tgd)
            $display("FAIL b2b_second_sb got %b/%0d/%h/%h want 1/%0d/%h/%h", got, st, d, t, e.st, e.data, e.tgd); else passed++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write();
        test_read_hold();
        test_retry(1'b0);
        test_retry(1'b1);
        test_priority();
        test_timeout();
        test_reset_mid_bus();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
